// File: rtl/pwm_init_arbiter.sv
// pwm_init_arbiter: clears the pixmap, loads the delay table and enables the
// PWM engine, sharing one registered write port with host requests.
module pwm_init_arbiter #(
  parameter logic [15:0] DELAY_BASE  = 16'h0010,
  parameter logic [15:0] DELAY_STEP  = 16'h0004,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        host_req,
  input  logic [10:0] host_addr,
  input  logic [15:0] host_din,
  output logic        host_ack,
  output logic [10:0] pwm_addr,
  output logic [15:0] pwm_din,
  output logic        pwm_we
);

  typedef enum logic [2:0] {
    IDLE,
    CLR_PIX,
    LOAD_TBL,
    ENABLE,
    FIN
  } state_t;

  state_t      state, state_n;
  logic [9:0]  idx, idx_n;
  logic [10:0] addr_n;
  logic [15:0] din_n;
  logic        we_n, busy_n, done_n, ack_n;
  logic [15:0] tbl_val;

  assign tbl_val = DELAY_BASE + ({8'h00, idx[7:0]} * DELAY_STEP);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = pwm_addr;
    din_n   = pwm_din;
    we_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    ack_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CLR_PIX;
          idx_n   = '0;
        end else if (host_req && !host_ack) begin
          // host_ack gates a still-held req so writes are >= 2 cycles apart
          we_n   = 1'b1;
          ack_n  = 1'b1;
          addr_n = host_addr;
          din_n  = host_din;
        end
      end
      CLR_PIX: begin
        we_n   = 1'b1;
        busy_n = 1'b1;
        addr_n = {1'b0, idx};
        din_n  = {8'h00, CLEAR_VALUE};
        idx_n  = idx + 10'd1;
        if (idx == 10'd1023) state_n = LOAD_TBL;
      end
      LOAD_TBL: begin
        we_n   = 1'b1;
        busy_n = 1'b1;
        addr_n = {3'b100, idx[7:0]};
        din_n  = tbl_val;
        idx_n  = idx + 10'd1;
        if (idx[7:0] == 8'hFF) begin
          state_n = ENABLE;
          idx_n   = '0;
        end
      end
      ENABLE: begin
        we_n    = 1'b1;
        busy_n  = 1'b1;
        addr_n  = 11'h755;
        din_n   = 16'h0023;
        state_n = FIN;
      end
      FIN: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      host_ack <= 1'b0;
      pwm_we   <= 1'b0;
      pwm_addr <= '0;
      pwm_din  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      busy     <= busy_n;
      done     <= done_n;
      host_ack <= ack_n;
      pwm_we   <= we_n;
      pwm_addr <= addr_n;
      pwm_din  <= din_n;
    end
  end

endmodule

// File: tb/tb_pwm_init_arbiter.sv
// tb_pwm_init_arbiter: host-write vector table, random host traffic against
// a reference model, and full init sequences with default and wrapping params.
module tb_pwm_init_arbiter;

  logic        cpu_clk;
  logic        reset;
  logic        start;
  logic        host_req;
  logic [10:0] host_addr;
  logic [15:0] host_din;

  logic        busy, done, host_ack, pwm_we;
  logic [10:0] pwm_addr;
  logic [15:0] pwm_din;

  logic        w_busy, w_done, w_ack, w_we;
  logic [10:0] w_addr;
  logic [15:0] w_din;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_init_arbiter dut (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .host_req (host_req),
    .host_addr(host_addr),
    .host_din (host_din),
    .host_ack (host_ack),
    .pwm_addr (pwm_addr),
    .pwm_din  (pwm_din),
    .pwm_we   (pwm_we)
  );

  pwm_init_arbiter #(
    .DELAY_BASE(16'hFFF0),
    .DELAY_STEP(16'h0010)
  ) dut_w (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .start    (start),
    .busy     (w_busy),
    .done     (w_done),
    .host_req (host_req),
    .host_addr(host_addr),
    .host_din (host_din),
    .host_ack (w_ack),
    .pwm_addr (w_addr),
    .pwm_din  (w_din),
    .pwm_we   (w_we)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [10:0] addr;
    logic [15:0] din;
    logic [10:0] exp_addr;
    logic [15:0] exp_din;
  } hvec_t;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // {we, addr, din, busy, done, ack}
  function automatic logic [30:0] act_d();
    return {pwm_we, pwm_addr, pwm_din, busy, done, host_ack};
  endfunction

  function automatic logic [30:0] act_w();
    return {w_we, w_addr, w_din, w_busy, w_done, w_ack};
  endfunction

  task automatic chk(input string name, input logic [30:0] act,
                     input logic [30:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write k of the init sequence as {addr, data}
  function automatic logic [26:0] exp_wr(int k, logic [15:0] base,
                                         logic [15:0] step);
    logic [15:0] slot;
    if (k < 1024) return {11'(k), 8'h00, 8'h00};
    slot = 16'(k - 1024);
    if (k < 1280) return {11'h400 + slot[10:0], 16'(base + slot * step)};
    return {11'h755, 16'h0023};
  endfunction

  task automatic run_seq(input bit with_host, input bit retrig);
    logic [26:0] e, ew;
    logic [10:0] la;
    logic [15:0] ld;
    start = 1'b1;
    if (with_host) begin
      host_req  = 1'b1;
      host_addr = 11'h2A5;
      host_din  = 16'h1111;
    end
    tick();
    start = 1'b0;
    for (int c = 1; c <= 1281; c++) begin
      start = retrig && (c == 101);
      if (with_host && c == 600) host_din = 16'hBEEF;
      tick();
      e  = exp_wr(c - 1, 16'h0010, 16'h0004);
      ew = exp_wr(c - 1, 16'hFFF0, 16'h0010);
      chk("seq", act_d(), {1'b1, e, 3'b100});
      chk("seq_wrap", act_w(), {1'b1, ew, 3'b100});
      if (c == 1025) chk("wrap_slot0", {15'd0, w_din}, {15'd0, 16'hFFF0});
      if (c == 1026) chk("wrap_slot1", {15'd0, w_din}, {15'd0, 16'h0000});
      if (c == 1280) chk("wrap_slot255", {15'd0, w_din}, {15'd0, 16'h0FE0});
    end
    start = retrig;
    tick();
    start = 1'b0;
    chk("done", act_d(), {1'b0, 11'h755, 16'h0023, 3'b010});
    chk("done_wrap", act_w(), {1'b0, 11'h755, 16'h0023, 3'b010});
    tick();
    if (with_host) begin
      chk("host_after_seq", act_d(), {1'b1, 11'h2A5, 16'hBEEF, 3'b001});
      host_req = 1'b0;
      la = 11'h2A5;
      ld = 16'hBEEF;
    end else begin
      chk("idle_after_seq", act_d(), {1'b0, 11'h755, 16'h0023, 3'b000});
      la = 11'h755;
      ld = 16'h0023;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("quiet_after_seq", act_d(), {1'b0, la, ld, 3'b000});
    end
  endtask

  hvec_t hv[5];

  initial begin
    logic        ack_m;
    logic [10:0] la;
    logic [15:0] ld;

    hv[0] = '{11'h123, 16'h00AB, 11'h123, 16'h00AB};
    hv[1] = '{11'h7FF, 16'hFFFF, 11'h7FF, 16'hFFFF};
    hv[2] = '{11'h400, 16'h5A5A, 11'h400, 16'h5A5A};
    hv[3] = '{11'h755, 16'h0000, 11'h755, 16'h0000};
    hv[4] = '{11'h000, 16'h8001, 11'h000, 16'h8001};

    reset     = 1'b1;
    start     = 1'b0;
    host_req  = 1'b0;
    host_addr = '0;
    host_din  = '0;
    tick();
    tick();
    chk("reset", act_d(), 31'd0);
    chk("reset_wrap", act_w(), 31'd0);
    reset = 1'b0;
    tick();
    chk("idle", act_d(), 31'd0);

    // Random host traffic in IDLE
    ack_m = 1'b0;
    la    = '0;
    ld    = '0;
    for (int i = 0; i < 300; i++) begin
      host_req  = ($urandom_range(0, 2) != 0);
      host_addr = 11'($urandom);
      host_din  = 16'($urandom);
      tick();
      if (host_req && !ack_m) begin
        la = host_addr;
        ld = host_din;
        chk("rand_host", act_d(), {1'b1, la, ld, 3'b001});
        ack_m = 1'b1;
      end else begin
        chk("rand_host", act_d(), {1'b0, la, ld, 3'b000});
        ack_m = 1'b0;
      end
    end
    host_req = 1'b0;
    tick();
    chk("rand_end", act_d(), {1'b0, la, ld, 3'b000});

    // Held host request: writes every second cycle, no address gating
    foreach (hv[i]) begin
      host_req  = 1'b1;
      host_addr = hv[i].addr;
      host_din  = hv[i].din;
      tick();
      chk("hv_write", act_d(), {1'b1, hv[i].exp_addr, hv[i].exp_din, 3'b001});
      tick();
      chk("hv_gap", act_d(), {1'b0, hv[i].exp_addr, hv[i].exp_din, 3'b000});
      tick();
      chk("hv_rewrite", act_d(), {1'b1, hv[i].exp_addr, hv[i].exp_din, 3'b001});
      host_req = 1'b0;
      tick();
      chk("hv_release", act_d(), {1'b0, hv[i].exp_addr, hv[i].exp_din, 3'b000});
    end

    run_seq(1'b0, 1'b0);
    run_seq(1'b1, 1'b1);

    // Reset in the middle of the clear phase
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 501; c++) begin
      tick();
      chk("pre_abort", act_d(), {1'b1, exp_wr(c - 1, 16'h0010, 16'h0004), 3'b100});
    end
    reset = 1'b1;
    tick();
    chk("abort_reset", act_d(), 31'd0);
    reset = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      tick();
      chk("post_abort", act_d(), 31'd0);
    end
    run_seq(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_init_arbiter.md
PWM_INIT_ARBITER -- requirements
Module: pwm_init_arbiter

Interface
REQ-001 The block SHALL have parameter DELAY_BASE, default 16'h0010, the delay value written to pwm table slot 0.
REQ-002 The block SHALL have parameter DELAY_STEP, default 16'h0004, the increment per table slot, 16-bit wrap.
REQ-003 The block SHALL have parameter CLEAR_VALUE, default 8'h00, the byte written to every pixmap location.
REQ-004 The block SHALL have port cpu_clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1, synchronous, active-high.
REQ-006 The block SHALL have port start, input, width 1, a request to run the init sequence.
REQ-007 The block SHALL have port busy, output, width 1, high while the sequence runs.
REQ-008 The block SHALL have port done, output, width 1, a one-cycle pulse when the sequence completes.
REQ-009 The block SHALL have port host_req, input, width 1, a host write request held until acked.
REQ-010 The block SHALL have port host_addr, input, width 11, the host write address.
REQ-011 The block SHALL have port host_din, input, width 16, the host write data.
REQ-012 The block SHALL have port host_ack, output, width 1, a one-cycle pulse marking the host write as issued.
REQ-013 The block SHALL have port pwm_addr, output, width 11, the PWM engine write address.
REQ-014 The block SHALL have port pwm_din, output, width 16, the PWM engine write data.
REQ-015 The block SHALL have port pwm_we, output, width 1, the PWM engine write strobe; one write per high cycle.

Function
REQ-016 The FSM SHALL have states IDLE, CLR_PIX, LOAD_TBL, ENABLE and FIN.
REQ-017 pwm_addr, pwm_din, pwm_we, busy, done and host_ack SHALL all be registered outputs.
REQ-018 In IDLE with start=1, the next state SHALL be CLR_PIX and a 10-bit index SHALL clear to 0.
REQ-019 start SHALL have priority over host_req when both are asserted in the same cycle.
REQ-020 In CLR_PIX, each cycle SHALL issue one write:
- pwm_addr = {1'b0, idx}, pwm_din = {8'h00, CLEAR_VALUE}, pwm_we = 1;
- after idx = 1023, idx SHALL clear and the state SHALL go to LOAD_TBL.
REQ-021 In LOAD_TBL, each cycle SHALL issue one write:
- pwm_addr = {3'b100, idx[7:0]}, pwm_din = DELAY_BASE + idx*DELAY_STEP (truncated to 16 bits), pwm_we = 1;
- after idx = 255, the state SHALL go to ENABLE.
REQ-022 In ENABLE, the block SHALL issue one write (pwm_addr = 11'h755, pwm_din = 16'h0023, pwm_we = 1) and go to FIN.
REQ-023 In FIN, the block SHALL assert done for one cycle, drive pwm_we = 0, and return to IDLE.
REQ-024 Timing: if start is sampled at edge N, write k (k = 0..1280) SHALL appear in cycle N+1+k.
- busy SHALL be high for cycles N+1..N+1281.
- done SHALL be high in cycle N+1282.
REQ-025 start while busy, or in the FIN cycle, SHALL be ignored; there is no queuing.
REQ-026 In IDLE with host_req=1, start=0 and host_ack=0:
- the block SHALL drive pwm_addr = host_addr, pwm_din = host_din, pwm_we = 1 and host_ack = 1 in the next cycle;
- host_ack SHALL return to 0 in the following cycle, so back-to-back host writes issue at most every 2 cycles.
REQ-027 host_req asserted during CLR_PIX..FIN SHALL be stalled, with host_ack = 0.
- The request SHALL be served in the first IDLE cycle after FIN.
- Host data SHALL be sampled at service time, not at request time.
REQ-028 When no write is issued, pwm_we SHALL be 0; pwm_addr and pwm_din hold their last values.
REQ-029 The block SHALL NOT gate host addresses: host writes into 0x400-0x7FF pass unchanged, and the PWM engine disables itself in response.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL enter IDLE.
- idx = 0; busy = 0; done = 0; host_ack = 0; pwm_we = 0; pwm_addr = 0; pwm_din = 0.
REQ-031 Reset mid-sequence SHALL abort with no further writes and no done pulse; a new start is required to rerun.

Verification
REQ-032 Start pulse with defaults -> 1024 writes (addr 0x000..0x3FF, data 0x0000), then 256 writes (addr 0x400..0x4FF, data 0x0010 + 4*i), then addr 0x755 / data 0x0023; done at cycle N+1282.
REQ-033 Table wrap check with DELAY_BASE = 16'hFFF0 and DELAY_STEP = 16'h0010 -> slot 0 = 0xFFF0, slot 1 = 0x0000, slot 255 = 0x0FE0.
REQ-034 Host write in IDLE (addr 0x123, data 0x00AB, req held) -> one write of 0x00AB to 0x123 with host_ack in the same cycle; the next write comes no earlier than 2 cycles later.
REQ-035 start and host_req in the same cycle -> the sequence runs first; the host is acked in cycle N+1283 with its current data.
REQ-036 Reset asserted at write 500 -> pwm_we = 0 from the next cycle, busy = 0, no done pulse; a subsequent start reruns from addr 0x000.
REQ-037 start pulsed again at write 100 -> ignored; the total write count stays 1281.
